mem_burst_seq: RTL

Parametrised cache-line burst sequencer between the cache controller FSM and the banked main memory. On `start`, it sequences `WORDS` word accesses, either a writeback (evict) or a fill. It generates the word index for each memory access and, for fills, the index and write strobe used to load returning data into the cache data array. It honours memory stall and fixed read latency, and pulses `done` once the whole line has completed.

---
 rtl/mem_burst_pkg.sv | 19 +
 rtl/mem_burst_seq_if.sv | 28 ++
 rtl/mem_ret_pipe.sv | 37 +++
 rtl/mem_burst_seq.sv | 106 ++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and defaults for the cache-line burst sequencer.
package mem_burst_pkg;

  localparam int unsigned DefaultWords = 4;
  localparam int unsigned DefaultRdLat = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  typedef enum logic {
    MODE_FILL = 1'b0,
    MODE_WB   = 1'b1
  } mode_e;

endpackage

// File: rtl/mem_burst_seq_if.sv
// Control/memory/fill signal bundle of the burst sequencer; slave is the sequencer side.
interface mem_burst_seq_if #(
  parameter int unsigned IDX_W = 2
) ();

  logic             start;
  logic             wr;
  logic [IDX_W-1:0] crit_idx;
  logic             mem_stall;
  logic             mem_rd;
  logic             mem_wr;
  logic [IDX_W-1:0] mem_idx;
  logic             fill_wr;
  logic [IDX_W-1:0] fill_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, wr, crit_idx, mem_stall,
    input  mem_rd, mem_wr, mem_idx, fill_wr, fill_idx, busy, done
  );

  modport slave (
    input  start, wr, crit_idx, mem_stall,
    output mem_rd, mem_wr, mem_idx, fill_wr, fill_idx, busy, done
  );

endinterface

// File: rtl/mem_ret_pipe.sv
// Fixed-latency read-return tracker: RD_LAT-deep {valid, index} shift register, sync active-low clear.
module mem_ret_pipe #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [RD_LAT-1:0] valid_q;
  logic [IDX_W-1:0]  idx_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      // Empty slots carry index 0 so fill_idx idles at 0.
      idx_q[0]   <= in_valid ? in_idx : '0;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/mem_burst_seq.sv
// Cache-line burst sequencer (writeback or fill). Define MEM_BURST_CWF_EN for critical-word-first.
module mem_burst_seq
  import mem_burst_pkg::*;
#(
  parameter int unsigned WORDS  = DefaultWords,
  parameter int unsigned IDX_W  = $clog2(WORDS),
  parameter int unsigned RD_LAT = DefaultRdLat
) (
  input logic           clk,
  input logic           rst,
  mem_burst_seq_if.slave bus
);

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [IDX_W-1:0] base_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] ret_cnt_q;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] start_base;
  logic             accept;
  logic             last_issue;
  logic             last_ret;
  logic             pipe_valid;
  logic [IDX_W-1:0] pipe_idx;

`ifdef MEM_BURST_CWF_EN
  assign start_base = bus.crit_idx;
`else
  logic unused_crit_idx;
  assign unused_crit_idx = ^bus.crit_idx;
  assign start_base      = '0;
`endif

  // Natural IDX_W overflow gives the modulo-WORDS wrap.
  assign issue_idx  = base_q + cnt_q;
  assign accept     = (state_q == StIssue) && !bus.mem_stall;
  assign last_issue = accept && (cnt_q == IDX_W'(WORDS - 1));
  assign last_ret   = pipe_valid && (ret_cnt_q == IDX_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StIssue;
      StIssue: if (last_issue) state_d = (mode_q == MODE_WB) ? StDone : StDrain;
      StDrain: if (last_ret) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= MODE_FILL;
      base_q    <= '0;
      cnt_q     <= '0;
      ret_cnt_q <= '0;
    end else if (state_q == StIdle) begin
      if (bus.start) begin
        mode_q    <= mode_e'(bus.wr);
        base_q    <= start_base;
        cnt_q     <= '0;
        ret_cnt_q <= '0;
      end
    end else begin
      if (accept) cnt_q <= cnt_q + 1'b1;
      if (pipe_valid) ret_cnt_q <= ret_cnt_q + 1'b1;
    end
  end

  mem_ret_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_ret_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept && (mode_q == MODE_FILL)),
    .in_idx    (issue_idx),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_idx  = '0;
    bus.fill_wr  = pipe_valid;
    bus.fill_idx = pipe_idx;
    bus.busy     = (state_q != StIdle);
    bus.done     = (state_q == StDone);
    if (state_q == StIssue) begin
      bus.mem_rd  = (mode_q == MODE_FILL);
      bus.mem_wr  = (mode_q == MODE_WB);
      bus.mem_idx = issue_idx;
    end
  end

endmodule
